// File: rtl/rx_frame_ctrl.sv
// rx_frame_ctrl: hunts sync word, reads length, gates payload bits to the descrambler, times out and counts frames
// ports: clk, rst (sync, active high); i_enable, i_bit_valid, i_bit_data from the demodulator;
//   o_sync_valid, o_sync_data, o_sync_valid_pulse, o_rx_end_pulse to the descrambler;
//   o_frame_len, o_busy, o_frame_err, o_frame_cnt as frame status
module rx_frame_ctrl #(
  parameter logic [15:0] SYNC_WORD = 16'hEB90,
  parameter int MAX_ERR = 1,
  parameter int TIMEOUT = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_enable,
  input  logic        i_bit_valid,
  input  logic        i_bit_data,
  output logic        o_sync_valid,
  output logic        o_sync_data,
  output logic        o_sync_valid_pulse,
  output logic        o_rx_end_pulse,
  output logic [7:0]  o_frame_len,
  output logic        o_busy,
  output logic        o_frame_err,
  output logic [15:0] o_frame_cnt
);
  localparam int IW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {SEARCH, HEADER, PAYLOAD} state_t;
  state_t state, state_n;
  logic [15:0] window, window_n;
  logic [4:0] fill, fill_n;
  logic [7:0] len_sr, len_n;
  logic [2:0] hcnt;
  logic [10:0] pcnt;
  logic [IW-1:0] idle;
  logic end_pend, tmo, abort, go, match, hdr_done, last;
  logic sync_valid_n, sync_pulse_n, end_n, err_n;
  // event decode; abort (disable or timeout) outranks any bit arriving the same clk
  always_comb begin
    window_n = {window[14:0], i_bit_data};
    fill_n = (fill == 5'd16) ? fill : fill + 5'd1;
    len_n = {len_sr[6:0], i_bit_data};
    tmo = i_enable && state != SEARCH && idle == IW'(TIMEOUT - 1);
    abort = !i_enable || tmo;
    go = i_bit_valid && !abort;
    match = go && state == SEARCH && fill_n == 5'd16 && $countones(window_n ^ SYNC_WORD) <= MAX_ERR;
    hdr_done = go && state == HEADER && hcnt == 3'd7;
    last = go && state == PAYLOAD && pcnt == 11'd1;
  end
  always_ff @(posedge clk) state <= rst ? SEARCH : state_n;
  always_comb begin
    state_n = abort ? SEARCH : match ? HEADER : hdr_done ? (|len_n ? PAYLOAD : SEARCH) : last ? SEARCH : state;
  end
  always_comb begin
    sync_valid_n = go && state == PAYLOAD;
    sync_pulse_n = hdr_done && |len_n;
    end_n = end_pend || (abort && state == PAYLOAD);
    err_n = (abort && state != SEARCH) || (hdr_done && !(|len_n));
  end
  // end_pend delays the normal end pulse one clk so it never overlaps the last strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      window <= '0;
      fill <= '0;
      len_sr <= '0;
      hcnt <= '0;
      pcnt <= '0;
      idle <= '0;
      end_pend <= 1'b0;
      o_sync_valid <= 1'b0;
      o_sync_data <= 1'b0;
      o_sync_valid_pulse <= 1'b0;
      o_rx_end_pulse <= 1'b0;
      o_frame_len <= '0;
      o_busy <= 1'b0;
      o_frame_err <= 1'b0;
      o_frame_cnt <= '0;
    end else begin
      window <= (go && state == SEARCH) ? window_n : window;
      fill <= (state != SEARCH || !i_enable) ? 5'd0 : go ? fill_n : fill;
      len_sr <= (go && state == HEADER) ? len_n : len_sr;
      hcnt <= (state != HEADER) ? 3'd0 : go ? hcnt + 3'd1 : hcnt;
      pcnt <= hdr_done ? {len_n, 3'b000} : (go && state == PAYLOAD) ? pcnt - 11'd1 : pcnt;
      idle <= i_bit_valid ? '0 : idle + IW'(1);
      end_pend <= last;
      o_sync_valid <= sync_valid_n;
      o_sync_data <= sync_valid_n && i_bit_data;
      o_sync_valid_pulse <= sync_pulse_n;
      o_rx_end_pulse <= end_n;
      o_frame_len <= sync_pulse_n ? len_n : o_frame_len;
      o_busy <= state_n != SEARCH;
      o_frame_err <= err_n;
      o_frame_cnt <= o_frame_cnt + {15'd0, last};
    end
  end
endmodule

// File: tb/tb_rx_frame_ctrl.sv
// tb_rx_frame_ctrl: directed frames with a payload scoreboard and pulse timing checks
module tb_rx_frame_ctrl;
  logic clk = 1'b0;
  logic rst, i_enable, i_bit_valid, i_bit_data;
  logic o_sync_valid, o_sync_data, o_sync_valid_pulse, o_rx_end_pulse, o_busy, o_frame_err;
  logic [7:0] o_frame_len;
  logic [15:0] o_frame_cnt;
  int n_pass = 0, n_fail = 0, n_total = 0;
  int cyc = 0;
  int n_sync = 0, n_end = 0, n_err = 0, n_str = 0;
  int sync_cyc = -1, end_cyc = -1, err_cyc = -1, str_cyc = -1;
  int s_sync, s_end, s_err, s_str;
  int last_bit_edge, hdr_edge, drop_edge;
  logic q[$];
  rx_frame_ctrl #(.SYNC_WORD(16'hEB90), .MAX_ERR(1), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .i_enable(i_enable), .i_bit_valid(i_bit_valid), .i_bit_data(i_bit_data),
    .o_sync_valid(o_sync_valid), .o_sync_data(o_sync_data), .o_sync_valid_pulse(o_sync_valid_pulse),
    .o_rx_end_pulse(o_rx_end_pulse), .o_frame_len(o_frame_len), .o_busy(o_busy),
    .o_frame_err(o_frame_err), .o_frame_cnt(o_frame_cnt)
  );
  always #5 clk = ~clk;
  initial forever @(posedge clk) cyc++;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // output monitor: pops expected payload bits and timestamps every pulse
  initial forever begin
    @(negedge clk);
    if (o_sync_valid) begin
      n_str++;
      str_cyc = cyc;
      chk("strobe_expected", q.size() != 0, 1);
      if (q.size() != 0) chk("payload_data", o_sync_data, q.pop_front());
    end
    if (o_sync_valid_pulse) begin
      n_sync++;
      sync_cyc = cyc;
    end
    if (o_rx_end_pulse) begin
      n_end++;
      end_cyc = cyc;
      chk("end_no_overlap", o_sync_valid, 0);
    end
    if (o_frame_err) begin
      n_err++;
      err_cyc = cyc;
    end
  end
  task automatic snap();
    s_sync = n_sync;
    s_end = n_end;
    s_err = n_err;
    s_str = n_str;
  endtask
  task automatic send_bit(input logic b, input int gap, input logic pay);
    if (pay) q.push_back(b);
    i_bit_valid = 1'b1;
    i_bit_data = b;
    @(negedge clk);
    last_bit_edge = cyc;
    i_bit_valid = 1'b0;
    i_bit_data = 1'b0;
    repeat (gap) @(negedge clk);
  endtask
  task automatic send_word(input logic [15:0] w, input int n, input int gap);
    for (int i = n - 1; i >= 0; i--) send_bit(w[i], gap, 1'b0);
  endtask
  task automatic frame(input logic [15:0] sw, input logic [7:0] len, input int npay, input int gap);
    send_word(sw, 16, gap);
    chk("busy_after_sync", o_busy, 1);
    send_word({8'd0, len}, 8, gap);
    hdr_edge = last_bit_edge;
    for (int i = 0; i < npay; i++) send_bit(1'($urandom), gap, 1'b1);
  endtask
  task automatic flush();
    i_enable = 1'b0;
    repeat (2) @(negedge clk);
    i_enable = 1'b1;
    @(negedge clk);
  endtask
  initial begin
    rst = 1'b1;
    i_enable = 1'b1;
    i_bit_valid = 1'b0;
    i_bit_data = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {o_sync_valid, o_sync_data, o_sync_valid_pulse, o_rx_end_pulse, o_frame_len, o_busy, o_frame_err, o_frame_cnt}, 0);
    rst = 1'b0;
    @(negedge clk);
    // clean frame, continuous bits
    snap();
    frame(16'hEB90, 8'd3, 24, 0);
    chk("cnt_at_u1", o_frame_cnt, 1);
    repeat (4) @(negedge clk);
    chk("t1_sync_cnt", n_sync - s_sync, 1);
    chk("t1_sync_time", sync_cyc, hdr_edge);
    chk("t1_strobes", n_str - s_str, 24);
    chk("t1_last_strobe", str_cyc, last_bit_edge);
    chk("t1_end_cnt", n_end - s_end, 1);
    chk("t1_end_time", end_cyc, last_bit_edge + 1);
    chk("t1_err_cnt", n_err - s_err, 0);
    chk("t1_len", o_frame_len, 3);
    chk("t1_busy", o_busy, 0);
    chk("t1_queue", q.size(), 0);
    // one-bit sync error accepted
    snap();
    frame(16'hEB91, 8'd1, 8, 0);
    repeat (4) @(negedge clk);
    chk("eb91_strobes", n_str - s_str, 8);
    chk("eb91_end", n_end - s_end, 1);
    chk("eb91_cnt", o_frame_cnt, 2);
    // two-bit sync error rejected
    snap();
    send_word(16'hEB93, 16, 0);
    chk("eb93_busy", o_busy, 0);
    send_word(16'h0001, 8, 0);
    repeat (4) @(negedge clk);
    chk("eb93_sync", n_sync - s_sync, 0);
    chk("eb93_err", n_err - s_err, 0);
    chk("eb93_busy_end", o_busy, 0);
    flush();
    // sparse bits, one valid every 5th clk
    snap();
    frame(16'hEB90, 8'd1, 8, 4);
    repeat (4) @(negedge clk);
    chk("sparse_sync", n_sync - s_sync, 1);
    chk("sparse_strobes", n_str - s_str, 8);
    chk("sparse_end_time", end_cyc, last_bit_edge + 1);
    chk("sparse_cnt", o_frame_cnt, 3);
    // zero length field
    snap();
    frame(16'hEB90, 8'd0, 0, 0);
    repeat (4) @(negedge clk);
    chk("zero_err", n_err - s_err, 1);
    chk("zero_err_time", err_cyc, hdr_edge);
    chk("zero_sync", n_sync - s_sync, 0);
    chk("zero_end", n_end - s_end, 0);
    chk("zero_cnt", o_frame_cnt, 3);
    chk("zero_len_kept", o_frame_len, 1);
    chk("zero_busy", o_busy, 0);
    // timeout after 10 of 16 payload bits
    snap();
    frame(16'hEB90, 8'd2, 10, 0);
    repeat (70) @(negedge clk);
    chk("tmo_strobes", n_str - s_str, 10);
    chk("tmo_end", n_end - s_end, 1);
    chk("tmo_err", n_err - s_err, 1);
    chk("tmo_end_time", end_cyc, last_bit_edge + 64);
    chk("tmo_err_time", err_cyc, last_bit_edge + 64);
    chk("tmo_cnt", o_frame_cnt, 3);
    chk("tmo_busy", o_busy, 0);
    chk("tmo_queue", q.size(), 0);
    // enable drop mid-payload, then a clean frame
    snap();
    frame(16'hEB90, 8'd2, 5, 0);
    i_enable = 1'b0;
    @(negedge clk);
    drop_edge = cyc;
    i_enable = 1'b1;
    repeat (3) @(negedge clk);
    chk("dis_end", n_end - s_end, 1);
    chk("dis_err", n_err - s_err, 1);
    chk("dis_end_time", end_cyc, drop_edge);
    chk("dis_err_time", err_cyc, drop_edge);
    chk("dis_strobes", n_str - s_str, 5);
    chk("dis_busy", o_busy, 0);
    frame(16'hEB90, 8'd1, 8, 0);
    repeat (4) @(negedge clk);
    chk("dis_next_cnt", o_frame_cnt, 4);
    chk("dis_next_strobes", n_str - s_str, 13);
    // reset mid-payload, then a clean frame
    snap();
    frame(16'hEB90, 8'd2, 5, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_outputs", {o_sync_valid, o_sync_data, o_sync_valid_pulse, o_rx_end_pulse, o_frame_len, o_busy, o_frame_err, o_frame_cnt}, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_no_end", n_end - s_end, 0);
    chk("rst_no_err", n_err - s_err, 0);
    frame(16'hEB90, 8'd1, 8, 0);
    repeat (4) @(negedge clk);
    chk("rst_next_cnt", o_frame_cnt, 1);
    chk("rst_next_len", o_frame_len, 1);
    // back-to-back frames without gap
    snap();
    frame(16'hEB90, 8'd1, 8, 0);
    frame(16'hEB90, 8'd2, 16, 0);
    repeat (6) @(negedge clk);
    chk("b2b_sync", n_sync - s_sync, 2);
    chk("b2b_end", n_end - s_end, 2);
    chk("b2b_strobes", n_str - s_str, 24);
    chk("b2b_cnt", o_frame_cnt, 3);
    chk("b2b_len", o_frame_len, 2);
    chk("b2b_busy", o_busy, 0);
    chk("b2b_queue", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
